shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-add multiplier; the multiply-direction counterpart to the restoring divider datapath.
- Instead of shifting the {A,Q} pair left and subtracting, it conditionally adds the multiplicand and shifts {C,A,Q} right, one bit per clock.
- Sits beside the divider in the arithmetic unit and shares its start/done handshake style.

---
 rtl/arith_pkg.sv | 19 +
 rtl/mul_shift_right_register.sv | 50 +++++
 rtl/shift_add_multiplier.sv | 81 ++++++++
 tb/tb_shift_add_multiplier.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Constants and types shared by the sequential arithmetic units (multiplier and divider).
package arith_pkg;

  localparam int unsigned Width = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mul_state_t;

  // Bits needed to hold an iteration count running from w down to 0.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CountWidth = count_width(Width);

endpackage

// File: rtl/mul_shift_right_register.sv
// Multiplicand and {C,A,Q} datapath: load operands, or conditionally add M and shift right by one.
module mul_shift_right_register
  import arith_pkg::*;
#(
  parameter int unsigned Width = arith_pkg::Width
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [Width-1:0]     m_i,
  input  logic [Width-1:0]     q_i,
  output logic [2*Width-1:0]   aq_next_o
);

  logic [Width-1:0] m_q, m_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width:0]   sum;

  always_comb begin
    // C is the carry of this add; after the shift it is always zero, so it is not stored.
    sum       = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : '0);
    aq_next_o = {sum, q_q[Width-1:1]};
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    if (load_i) begin
      m_d = m_i;
      a_d = '0;
      q_d = q_i;
    end else if (step_i) begin
      a_d = aq_next_o[2*Width-1:Width];
      q_d = aq_next_o[Width-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q <= '0;
      a_q <= '0;
      q_q <= '0;
    end else begin
      m_q <= m_d;
      a_q <= a_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one product bit per clock with a start/done handshake.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned Width = arith_pkg::Width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [Width-1:0]     multiplicand,
  input  logic [Width-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*Width-1:0]   product
);

  localparam int unsigned CntW = count_width(Width);

  mul_state_t             state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [2*Width-1:0]     product_q, product_d;
  logic [2*Width-1:0]     aq_next;
  logic                   load, step;

  mul_shift_right_register #(
    .Width(Width)
  ) u_sr (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .step_i   (step),
    .m_i      (multiplicand),
    .q_i      (multiplier),
    .aq_next_o(aq_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          count_d = CntW'(Width);
          state_d = StRun;
        end
      end
      StRun: begin
        step    = 1'b1;
        count_d = count_q - 1'b1;
        // Last iteration: capture the shifted result directly, it is not read back from A/Q.
        if (count_q == CntW'(1)) begin
          product_d = aq_next;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected products and acceptance edges are queued at start.
module tb_shift_add_multiplier;

  localparam int unsigned W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;
  int unsigned      edge_cnt = 0;
  logic [2*W-1:0]   exp_q[$];
  int unsigned      acc_q[$];

  shift_add_multiplier #(
    .Width(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .multiplicand(mcand),
    .multiplier  (mplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding request, WIDTH edges after acceptance.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        check("product", product, exp_q.pop_front());
        check("latency", edge_cnt - acc_q.pop_front(), W);
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at the negedge after acceptance.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    logic [2*W-1:0] e;
    e      = (2*W)'(m) * (2*W)'(q);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    exp_q.push_back(e);
    acc_q.push_back(edge_cnt + 1);
    @(negedge clk);
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (done !== 1'b1 && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (done !== 1'b1) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    rst = 1'b0;
    @(negedge clk);

    // Simple product and pulse width
    start_op(16'h0003, 16'h0005);
    check("busy_after_start", busy, 1);
    wait_done("simple");
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);

    // Extreme operands
    start_op(16'hFFFF, 16'hFFFF);
    wait_done("ffff");
    @(negedge clk);
    start_op(16'h0000, 16'h1234);
    wait_done("zero");
    @(negedge clk);

    // Start held through a whole run with operands churning after acceptance
    start  = 1'b1;
    mcand  = 16'h00FF;
    mplier = 16'h0101;
    exp_q.push_back(32'h0000FFFF);
    acc_q.push_back(edge_cnt + 1);
    @(negedge clk);
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      mcand  = W'($urandom);
      mplier = W'($urandom);
      @(negedge clk);
    end
    if (done !== 1'b1) check("held_timeout", 64'd0, 64'd1);
    // start stays high through DONE; it must be picked up only once back in IDLE
    mcand  = 16'h1234;
    mplier = 16'h0002;
    @(negedge clk);
    check("start_in_done_dropped", busy, 0);
    exp_q.push_back(32'h00002468);
    acc_q.push_back(edge_cnt + 1);
    @(negedge clk);
    check("accepted_in_idle", busy, 1);
    start = 1'b0;
    wait_done("after_done");
    @(negedge clk);

    // Reset on the 8th RUN edge
    start_op(16'hABCD, 16'h0010);
    repeat (7) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (25) @(negedge clk);
    check("no_done_after_abort", busy, 0);

    start_op(16'hABCD, 16'h0010);
    wait_done("fresh");
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
